hamming_stream_ctrl: RTL and testbench

Streaming scheduler that shares one Hamming(7,4) encode/decode datapath between an encode requester and a decode requester. Each requester has its own valid/ready channel, and a 2-way round-robin arbiter grants the datapath. One result per cycle is registered into a single-entry output stage with its own valid/ready handshake. An optional saturating counter tracks decode words that had a nonzero syndrome.

---
 rtl/hamming_pkg.sv | 18 +
 rtl/hamming_rr_arb2.sv | 29 ++
 rtl/hamming_stream_ctrl.sv | 122 ++++++++++++
 tb/tb_hamming_stream_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared widths, channel and output-stage types for hamming_stream_ctrl
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;
  localparam int SYN_W  = 3;

  typedef enum logic {
    CH_ENC = 1'b0,
    CH_DEC = 1'b1
  } ch_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/hamming_rr_arb2.sv
// rtl/hamming_rr_arb2.sv - two-requester round-robin arbiter; req[0]=encode, req[1]=decode
module hamming_rr_arb2
  import hamming_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output ch_t        last_grant
);

  // On a tie the channel that was not served last wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == CH_DEC) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= CH_DEC;
    end else if (advance && (grant != 2'b00)) begin
      last_grant <= grant[1] ? CH_DEC : CH_ENC;
    end
  end

endmodule

// File: rtl/hamming_stream_ctrl.sv
// rtl/hamming_stream_ctrl.sv - shared Hamming(7,4) encode/decode scheduler; HAMMING_ERR_CNT_EN adds err_clr/err_count
module hamming_stream_ctrl
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [DATA_W-1:0] enc_data,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [CODE_W-1:0] dec_code,
`ifdef HAMMING_ERR_CNT_EN
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_count,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_dec,
  output logic [CODE_W-1:0] out_word,
  output logic              out_err
);

  out_state_t        state;
  out_state_t        state_nxt;
  logic              can_accept;
  logic [1:0]        grant;
  ch_t               last_grant;
  logic              xfer;
  logic [CODE_W-1:0] enc_code;
  logic [SYN_W-1:0]  syn;
  logic [CODE_W-1:0] fixed_code;
  logic [DATA_W-1:0] dec_data;
  logic [CODE_W-1:0] res_word;
  logic              res_err;

  // Encoder: c = {d3, d2, d1, p4, d0, p2, p1}
  always_comb begin
    enc_code = {enc_data[3], enc_data[2], enc_data[1],
                enc_data[1] ^ enc_data[2] ^ enc_data[3],
                enc_data[0],
                enc_data[0] ^ enc_data[2] ^ enc_data[3],
                enc_data[0] ^ enc_data[1] ^ enc_data[3]};
  end

  // Decoder: the syndrome names the 1-based position of a single flipped bit.
  always_comb begin
    syn = {dec_code[3] ^ dec_code[4] ^ dec_code[5] ^ dec_code[6],
           dec_code[1] ^ dec_code[2] ^ dec_code[5] ^ dec_code[6],
           dec_code[0] ^ dec_code[2] ^ dec_code[4] ^ dec_code[6]};
    fixed_code = dec_code;
    for (int i = 0; i < CODE_W; i++) begin
      if (syn == SYN_W'(i + 1)) begin
        fixed_code[i] = ~dec_code[i];
      end
    end
    dec_data = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
  end

  hamming_rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        ({dec_valid, enc_valid}),
    .advance    (xfer),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign can_accept = (state == OUT_EMPTY) || out_ready;
  assign enc_ready  = rst_n && can_accept && grant[0];
  assign dec_ready  = rst_n && can_accept && grant[1];
  assign xfer       = (enc_valid && enc_ready) || (dec_valid && dec_ready);

  assign res_word = grant[1] ? {3'b000, dec_data} : enc_code;
  assign res_err  = grant[1] && (syn != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (xfer) state_nxt = OUT_FULL;
      OUT_FULL:  if (out_ready && !xfer) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  assign out_valid = (state == OUT_FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_word   <= '0;
      out_is_dec <= 1'b0;
      out_err    <= 1'b0;
    end else if (xfer) begin
      out_word   <= res_word;
      out_is_dec <= grant[1];
      out_err    <= res_err;
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (xfer && res_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_stream_ctrl.sv
// tb/tb_hamming_stream_ctrl.sv - directed self-checking bench for hamming_stream_ctrl
module tb_hamming_stream_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enc_valid;
  logic       enc_ready;
  logic [3:0] enc_data;
  logic       dec_valid;
  logic       dec_ready;
  logic [6:0] dec_code;
  logic       out_valid;
  logic       out_ready;
  logic       out_is_dec;
  logic [6:0] out_word;
  logic       out_err;
`ifdef HAMMING_ERR_CNT_EN
  logic       err_clr;
  logic [1:0] err_count;
`endif

  int total;
  int bad;

  hamming_stream_ctrl #(.CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_valid  (enc_valid),
    .enc_ready  (enc_ready),
    .enc_data   (enc_data),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_code   (dec_code),
`ifdef HAMMING_ERR_CNT_EN
    .err_clr    (err_clr),
    .err_count  (err_count),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_is_dec (out_is_dec),
    .out_word   (out_word),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    enc_valid = 1'b1;
    enc_data = 4'h0;
    dec_valid = 1'b1;
    dec_code = 7'h00;
    out_ready = 1'b1;
`ifdef HAMMING_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_is_dec", out_is_dec, 0);
    check("rst_out_err", out_err, 0);
    check("rst_enc_ready", enc_ready, 0);
    check("rst_dec_ready", dec_ready, 0);
`ifdef HAMMING_ERR_CNT_EN
    check("rst_err_count", err_count, 0);
`endif

    // Encode 1011 -> 0x55
    rst_n = 1'b1;
    dec_valid = 1'b0;
    enc_data = 4'b1011;
    settle();
    check("enc_ready_single", enc_ready, 1);
    check("dec_ready_single", dec_ready, 0);
    tick();
    enc_valid = 1'b0;
    check("enc_out_valid", out_valid, 1);
    check("enc_out_word", out_word, 7'h55);
    check("enc_out_is_dec", out_is_dec, 0);
    check("enc_out_err", out_err, 0);
    tick();
    check("enc_drain", out_valid, 0);

    // Decode 0x51 (bit 2 flipped) -> 0x0B with error
    dec_valid = 1'b1;
    dec_code = 7'h51;
    settle();
    check("dec_ready_single", dec_ready, 1);
    tick();
    dec_valid = 1'b0;
    check("dec_out_valid", out_valid, 1);
    check("dec_out_word", out_word, 7'h0B);
    check("dec_out_is_dec", out_is_dec, 1);
    check("dec_out_err", out_err, 1);
`ifdef HAMMING_ERR_CNT_EN
    check("dec_err_count", err_count, 1);
`endif
    tick();
    check("dec_drain", out_valid, 0);

    // Tie: strict alternation starting with encode
    enc_valid = 1'b1;
    enc_data = 4'h1;
    dec_valid = 1'b1;
    dec_code = 7'h07;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("tie_enc_ready_%0d", i), enc_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("tie_dec_ready_%0d", i), dec_ready, (i % 2 == 0) ? 0 : 1);
      tick();
      check($sformatf("tie_valid_%0d", i), out_valid, 1);
      check($sformatf("tie_word_%0d", i), out_word, (i % 2 == 0) ? 7'h07 : 7'h01);
      check($sformatf("tie_is_dec_%0d", i), out_is_dec, (i % 2 == 0) ? 0 : 1);
      check($sformatf("tie_err_%0d", i), out_err, 0);
    end

    // Stall holds the pending word and blocks both requesters
    out_ready = 1'b0;
    settle();
    check("stall_enc_ready", enc_ready, 0);
    check("stall_dec_ready", dec_ready, 0);
    tick();
    check("stall_valid", out_valid, 1);
    check("stall_word", out_word, 7'h01);
    check("stall_is_dec", out_is_dec, 1);
    out_ready = 1'b1;
    settle();
    check("b2b_enc_ready", enc_ready, 1);
    tick();
    check("b2b_valid", out_valid, 1);
    check("b2b_word", out_word, 7'h07);
    check("b2b_is_dec", out_is_dec, 0);
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    tick();
    check("b2b_drain", out_valid, 0);

`ifdef HAMMING_ERR_CNT_EN
    // Counter (CNT_W=2) starts at 1 here and saturates at 3
    dec_valid = 1'b1;
    dec_code = 7'h51;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_count_%0d", i), err_count, (i < 2) ? i + 2 : 3);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    dec_valid = 1'b0;
    check("clr_wins_count", err_count, 0);
    check("clr_out_err", out_err, 1);
    tick();
    check("clr_drain", out_valid, 0);
`endif

    // Leave an encode result pending with last_grant=encode, then reset
    dec_valid = 1'b1;
    dec_code = 7'h51;
    out_ready = 1'b0;
    tick();
    dec_valid = 1'b0;
    out_ready = 1'b1;
    enc_valid = 1'b1;
    enc_data = 4'b1011;
    tick();
    enc_valid = 1'b0;
    out_ready = 1'b0;
    check("pre_rst_word", out_word, 7'h55);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    enc_valid = 1'b1;
    dec_valid = 1'b1;
    out_ready = 1'b1;
    settle();
    check("mid_rst_enc_ready", enc_ready, 0);
    check("mid_rst_dec_ready", dec_ready, 0);
    tick();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_word", out_word, 0);
    check("post_rst_is_dec", out_is_dec, 0);
    check("post_rst_err", out_err, 0);
`ifdef HAMMING_ERR_CNT_EN
    check("post_rst_count", err_count, 0);
`endif
    rst_n = 1'b1;
    settle();
    check("post_rst_tie_enc", enc_ready, 1);
    check("post_rst_tie_dec", dec_ready, 0);
    tick();
    check("post_rst_first_word", out_word, 7'h55);
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
